// File: rtl/scan_test_if.sv
// Handshake and scan-port bundle between a scan test controller and its user/chain.
interface scan_test_if #(parameter int CHAIN_LEN = 4);
   logic                 start;
   logic [CHAIN_LEN-1:0] pattern;
   logic [CHAIN_LEN-1:0] expected;
   logic                 scan_out;
   logic                 scan_en;
   logic                 scan_in;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [CHAIN_LEN-1:0] captured;
   logic [CHAIN_LEN-1:0] fail_mask;

   modport master (output start, pattern, expected, scan_out,
                   input  scan_en, scan_in, busy, done, pass, captured, fail_mask);
   modport slave  (input  start, pattern, expected, scan_out,
                   output scan_en, scan_in, busy, done, pass, captured, fail_mask);
endinterface

// File: rtl/scan_test_controller.sv
// Runs one scan pattern: shift in, one capture cycle, shift out, compare against expected.
//
// state       | meaning
// S_IDLE      | waiting for start, scan outputs low
// S_SHIFT_IN  | CHAIN_LEN cycles loading pattern MSB first
// S_CAPTURE   | one functional cycle, chain loads next-state
// S_SHIFT_OUT | CHAIN_LEN cycles unloading the chain
// S_DONE      | one cycle result pulse, start accepted back-to-back
module scan_test_controller #(
   parameter int CHAIN_LEN = 4
) (
   input  logic        clk,
   input  logic        reset,
   scan_test_if.slave  bus
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SHIFT_IN  = 3'd1;
   localparam logic [2:0] S_CAPTURE   = 3'd2;
   localparam logic [2:0] S_SHIFT_OUT = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] pat_q, pat_d;
   logic [CHAIN_LEN-1:0] exp_q, exp_d;
   logic [CHAIN_LEN-1:0] sh_q, sh_d;
   logic                 scan_en_q, scan_en_d;
   logic                 scan_in_q, scan_in_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [CHAIN_LEN-1:0] captured_q, captured_d;
   logic [CHAIN_LEN-1:0] fail_mask_q, fail_mask_d;
   logic [CHAIN_LEN-1:0] cap_next;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pat_d       = pat_q;
      exp_d       = exp_q;
      sh_d        = sh_q;
      scan_en_d   = scan_en_q;
      scan_in_d   = scan_in_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      captured_d  = captured_q;
      fail_mask_d = fail_mask_q;
      // first unloaded bit ends up in the MSB after CHAIN_LEN shifts
      cap_next    = {sh_q[CHAIN_LEN-2:0], bus.scan_out};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d   = S_SHIFT_IN;
               cnt_d     = '0;
               pat_d     = bus.pattern << 1;
               exp_d     = bus.expected;
               scan_en_d = 1'b1;
               scan_in_d = bus.pattern[CHAIN_LEN-1];
               busy_d    = 1'b1;
            end else begin
               state_d   = S_IDLE;
               scan_en_d = 1'b0;
               scan_in_d = 1'b0;
               busy_d    = 1'b0;
            end
         end
         S_SHIFT_IN: begin
            if (cnt_q == LAST) begin
               state_d   = S_CAPTURE;
               cnt_d     = '0;
               scan_en_d = 1'b0;
               scan_in_d = 1'b0;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               scan_in_d = pat_q[CHAIN_LEN-1];
               pat_d     = pat_q << 1;
            end
         end
         S_CAPTURE: begin
            state_d   = S_SHIFT_OUT;
            cnt_d     = '0;
            scan_en_d = 1'b1;
            scan_in_d = 1'b0;
         end
         S_SHIFT_OUT: begin
            sh_d = cap_next;
            if (cnt_q == LAST) begin
               state_d     = S_DONE;
               cnt_d       = '0;
               scan_en_d   = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               captured_d  = cap_next;
               fail_mask_d = cap_next ^ exp_q;
               pass_d      = (cap_next == exp_q);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            scan_en_d = 1'b0;
            scan_in_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pat_q       <= '0;
         exp_q       <= '0;
         sh_q        <= '0;
         scan_en_q   <= 1'b0;
         scan_in_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         captured_q  <= '0;
         fail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         exp_q       <= exp_d;
         sh_q        <= sh_d;
         scan_en_q   <= scan_en_d;
         scan_in_q   <= scan_in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         captured_q  <= captured_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign bus.scan_en   = scan_en_q;
   assign bus.scan_in   = scan_in_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.captured  = captured_q;
   assign bus.fail_mask = fail_mask_q;
endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller driving a 4-bit incrementer with a scan chain.
module tb_scan_test_controller;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   scan_test_if #(.CHAIN_LEN(N)) bus();
   scan_test_controller #(.CHAIN_LEN(N)) u_dut (.clk(clk), .reset(reset), .bus(bus));

   // attached circuit: 4-bit incrementer whose state flops form the scan chain
   logic [N-1:0] chain = '0;
   always @(posedge clk) begin
      if (bus.scan_en) chain <= {chain[N-2:0], bus.scan_in};
      else             chain <= chain + 4'd1;
   end
   assign bus.scan_out = chain[N-1];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

   // model: t = cycles since the accepting edge, -1 when no pattern active
   int           t = -1;
   logic [N-1:0] m_pat = '0, m_exp = '0, m_cap = '0, m_fm = '0;
   logic         m_pass = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t = -1; m_cap = '0; m_fm = '0; m_pass = 1'b0;
      end else if ((t < 0 || t == 2*N+1) && bus.start) begin
         t = 0; m_pat = bus.pattern; m_exp = bus.expected;
      end else if (t >= 0 && t < 2*N+1) begin
         t++;
         if (t == 2*N+1) begin
            m_cap  = m_pat + 4'd1;
            m_fm   = m_cap ^ m_exp;
            m_pass = (m_cap == m_exp);
         end
      end else begin
         t = -1;
      end
   end

   always @(negedge clk) begin
      logic e_en, e_in, e_busy, e_done;
      if (!reset) begin
         e_en   = (t >= 0 && t < N) || (t > N && t <= 2*N);
         e_in   = (t >= 0 && t < N) ? m_pat[N-1-t] : 1'b0;
         e_busy = (t >= 0 && t <= 2*N);
         e_done = (t == 2*N+1);
         chk("scan_en", 32'(bus.scan_en), 32'(e_en));
         chk("scan_in", 32'(bus.scan_in), 32'(e_in));
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("done", 32'(bus.done), 32'(e_done));
         chk("pass", 32'(bus.pass), 32'(m_pass));
         chk("captured", 32'(bus.captured), 32'(m_cap));
         chk("fail_mask", 32'(bus.fail_mask), 32'(m_fm));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_scan_en"}, 32'(bus.scan_en), 0);
      chk({tag, "_scan_in"}, 32'(bus.scan_in), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_pass"}, 32'(bus.pass), 0);
      chk({tag, "_captured"}, 32'(bus.captured), 0);
      chk({tag, "_fail_mask"}, 32'(bus.fail_mask), 0);
   endtask

   task automatic run(input logic [N-1:0] p, input logic [N-1:0] e, input bit ghost,
                      output int dn, output logic [3:0] sin_seq, output logic [4:0] en_seq);
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = p; bus.expected = e;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.pattern = ~p; bus.expected = ~e;
      dn = -1; sin_seq = '0; en_seq = '0;
      for (int n = 0; n < 20 && dn < 0; n++) begin
         @(negedge clk);
         if (n < 4) sin_seq = {sin_seq[2:0], bus.scan_in};
         if (n < 5) en_seq = {en_seq[3:0], bus.scan_en};
         if (bus.done === 1'b1) dn = n;
         bus.start = ghost && (n == 3 || n == 7);
      end
      bus.start = 1'b0;
      if (dn < 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int dn, d0, n1, n2;
      logic [3:0] sseq;
      logic [4:0] eseq;
      reset = 1'b1; bus.start = 1'b0; bus.pattern = '0; bus.expected = '0;
      #2;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      run(4'b0101, 4'b0110, 1'b0, dn, sseq, eseq);
      chk("lat_0101", dn, 9);
      chk("sin_seq_0101", 32'(sseq), 32'h5);
      chk("en_seq_0101", 32'(eseq), 32'h1e);
      chk("cap_0101", 32'(bus.captured), 32'h6);
      chk("pass_0101", 32'(bus.pass), 1);
      chk("fm_0101", 32'(bus.fail_mask), 0);

      run(4'b1111, 4'b0000, 1'b0, dn, sseq, eseq);
      chk("cap_wrap", 32'(bus.captured), 0);
      chk("pass_wrap", 32'(bus.pass), 1);

      run(4'b0101, 4'b0111, 1'b0, dn, sseq, eseq);
      chk("pass_bad", 32'(bus.pass), 0);
      chk("cap_bad", 32'(bus.captured), 32'h6);
      chk("fm_bad", 32'(bus.fail_mask), 32'h1);
      repeat (3) @(negedge clk);

      d0 = done_cnt;
      run(4'b0011, 4'b0100, 1'b1, dn, sseq, eseq);
      chk("lat_ghost", dn, 9);
      repeat (12) @(negedge clk);
      chk("ghost_one_done", done_cnt - d0, 1);

      // start held high straight through the first DONE
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 4'b0101; bus.expected = 4'b0110;
      @(posedge clk); #1;
      bus.pattern = 4'b1111; bus.expected = 4'b0000;
      n1 = -1; n2 = -1;
      for (int n = 0; n < 40 && n2 < 0; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (n1 < 0) begin
               n1 = n;
               chk("b2b_cap1", 32'(bus.captured), 32'h6);
            end else begin
               n2 = n;
               bus.start = 1'b0;
               chk("b2b_cap2", 32'(bus.captured), 0);
               chk("b2b_pass2", 32'(bus.pass), 1);
            end
         end
      end
      bus.start = 1'b0;
      chk("b2b_lat1", n1, 9);
      chk("b2b_gap", n2 - n1, 10);
      repeat (3) @(negedge clk);

      // reset in SHIFT_OUT cycle 2 (cycle 7 after acceptance)
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 4'b0101; bus.expected = 4'b0110;
      @(posedge clk); #1;
      bus.start = 1'b0;
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      #1 reset = 1'b1;
      #1 chk_all_zero("abort");
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);

      run(4'b0011, 4'b0100, 1'b0, dn, sseq, eseq);
      chk("post_rst_lat", dn, 9);
      chk("post_rst_pass", 32'(bus.pass), 1);
      chk("post_rst_cap", 32'(bus.captured), 32'h4);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/scan_test_controller.md
SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 Parameter: CHAIN_LEN, default 4, number of scan flops in the attached chain (>=2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one test pattern; sampled on rising edge.
REQ-005 pattern  input  CHAIN_LEN  stimulus to load into chain flops (bit i -> flop i).
REQ-006 expected  input  CHAIN_LEN  expected captured chain contents.
REQ-007 scan_out  input  1  serial output of chain (flop CHAIN_LEN-1).
REQ-008 scan_en  output  1  chain shift enable (1 = shift, 0 = functional capture).
REQ-009 scan_in  output  1  serial data into chain flop 0.
REQ-010 busy  output  1  high while a pattern is in progress.
REQ-011 done  output  1  one-cycle pulse when a result is valid.
REQ-012 pass  output  1  1 when captured == expected; valid from done, held until next start accepted.
REQ-013 captured  output  CHAIN_LEN  unloaded chain contents; held like pass.
REQ-014 fail_mask  output  CHAIN_LEN  captured XOR expected; held like pass.

Function
REQ-015 FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
REQ-016 IDLE: scan_en=0, scan_in=0, busy=0; start=1 latches pattern and expected, goes to SHIFT_IN, clears bit counter.
REQ-017 SHIFT_IN: exactly CHAIN_LEN cycles; scan_en=1; cycle k (k=0..CHAIN_LEN-1) drives scan_in=pattern[CHAIN_LEN-1-k] (MSB first), so flop i holds pattern[i] after the last edge.
REQ-018 CAPTURE: exactly 1 cycle; scan_en=0, scan_in=0; chain loads functional next-state.
REQ-019 SHIFT_OUT: exactly CHAIN_LEN cycles; scan_en=1, scan_in=0; at the edge ending cycle k, scan_out is sampled into captured[CHAIN_LEN-1-k].
REQ-020 DONE: 1 cycle; done=1, busy=0; pass/captured/fail_mask valid; next state IDLE, or SHIFT_IN if start=1 in this cycle (back-to-back accepted).
REQ-021 busy=1 in SHIFT_IN, CAPTURE, SHIFT_OUT only.
REQ-022 Latency: start accepted at edge E0 -> done high in cycle 2*CHAIN_LEN+1 after E0 (cycle 9 for CHAIN_LEN=4).
REQ-023 start asserted while busy=1 is ignored; pattern/expected changes after acceptance have no effect.
REQ-024 scan_en and scan_in driven directly from flops (no combinational path from any input).
REQ-025 Bit counter width clog2(CHAIN_LEN+1); no wrap beyond CHAIN_LEN-1 within a state.
REQ-026 pass=1 iff fail_mask==0; all three result outputs update only at the SHIFT_OUT->DONE edge.

Reset
REQ-027 reset=1 forces immediately: state IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, fail_mask=0, counter=0.
REQ-028 reset during any state aborts the pattern; no done pulse for the aborted pattern; first start after reset release runs a full sequence.

Verification (CHAIN_LEN=4, attached to 4-bit increment counter with scan chain)
REQ-029 pattern=0101, expected=0110 -> scan_in sequence 0,1,0,1 with scan_en=1 for 4 cycles, scan_en=0 one cycle, done in cycle 9, pass=1, captured=0110, fail_mask=0000.
REQ-030 pattern=1111, expected=0000 (counter wrap) -> pass=1, captured=0000.
REQ-031 pattern=0101, expected=0111 -> pass=0, captured=0110, fail_mask=0001.
REQ-032 start pulsed again in cycles 3 and 7 of a running pattern -> ignored; exactly one done at cycle 9.
REQ-033 start held high through DONE -> second pattern begins SHIFT_IN the next cycle; second done 10 cycles after first.
REQ-034 reset asserted during SHIFT_OUT cycle 2 -> all outputs 0 immediately, no done; a following pattern=0011, expected=0100 yields pass=1.
